// File: rtl/receptor_words.sv
// Oversampling UART receiver: checks start/parity/stop and packs BYTES
// characters into one word, with an inter-byte timeout that resyncs partial words.
module receptor_words #(
    parameter int DATA_BITS    = 8,
    parameter int BYTES        = 2,
    parameter int OVERSAMPLE   = 16,
    parameter int PARITY       = 0,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                          clk_153k6hz,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [DATA_BITS*BYTES-1:0]    data,
    output logic                          valid,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          timeout,
    output logic                          busy
);

    localparam int SC_W   = $clog2(OVERSAMPLE);
    localparam int BC_W   = $clog2(DATA_BITS + 1);
    localparam int IX_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_CYC = OVERSAMPLE * TIMEOUT_BITS;
    localparam int TO_W   = $clog2(TO_CYC);

    localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);
    localparam logic [IX_W-1:0] IX_LAST = IX_W'(BYTES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] BRK   = 3'd5;

    logic                         rx_m;
    logic                         rxs;
    logic [2:0]                   state;
    logic [SC_W-1:0]              sc;
    logic [BC_W-1:0]              bc;
    logic [DATA_BITS-1:0]         chr;
    logic                         pe;
    logic [IX_W-1:0]              idx;
    logic [TO_W-1:0]              tcnt;
    logic [DATA_BITS-1:0]         slot [BYTES];
    logic [DATA_BITS*BYTES-1:0]   word_nxt;
    logic                         par_exp;
    logic                         stop_good;

    assign busy      = (state != IDLE);
    assign par_exp   = (^chr) ^ (PARITY == 2);
    assign stop_good = (state == STOP) && (sc == SC_LAST) && rxs && !pe;

    always_ff @(posedge clk_153k6hz or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rxs  <= 1'b1;
        end else begin
            rx_m <= rx;
            rxs  <= rx_m;
        end
    end

    // The word presented on valid merges the stored slots with the character
    // completing in this cycle, since its slot write lands on the same edge.
    always_comb begin
        word_nxt = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            word_nxt[i*DATA_BITS +: DATA_BITS] = (IX_W'(i) == idx) ? chr : slot[i];
        end
    end

    always_ff @(posedge clk_153k6hz) begin
        if (stop_good) slot[idx] <= chr;
    end

    always_ff @(posedge clk_153k6hz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sc         <= '0;
            bc         <= '0;
            chr        <= '0;
            pe         <= 1'b0;
            idx        <= '0;
            tcnt       <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    // A start edge wins over a coincident timeout terminal count.
                    if (!rxs) begin
                        state <= START;
                        sc    <= '0;
                        tcnt  <= '0;
                    end else if (idx != '0) begin
                        if (tcnt == TO_LAST) begin
                            timeout <= 1'b1;
                            idx     <= '0;
                            tcnt    <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end else begin
                        tcnt <= '0;
                    end
                end
                START: begin
                    if (sc == SC_HALF) begin
                        if (!rxs) begin
                            state <= DATA;
                            sc    <= '0;
                            bc    <= '0;
                            pe    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                DATA: begin
                    if (sc == SC_LAST) begin
                        sc  <= '0;
                        chr <= {rxs, chr[DATA_BITS-1:1]};
                        if (bc == BC_LAST) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bc <= bc + 1'b1;
                        end
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                PAR: begin
                    if (sc == SC_LAST) begin
                        sc    <= '0;
                        pe    <= rxs ^ par_exp;
                        state <= STOP;
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                STOP: begin
                    if (sc == SC_LAST) begin
                        sc <= '0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            idx       <= '0;
                            state     <= BRK;
                        end else if (pe) begin
                            parity_err <= 1'b1;
                            idx        <= '0;
                            state      <= IDLE;
                        end else begin
                            if (idx == IX_LAST) begin
                                data  <= word_nxt;
                                valid <= 1'b1;
                                idx   <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                            state <= IDLE;
                        end
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                BRK: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_receptor_words.sv
// Directed bench for receptor_words: 8N1 instance plus an 8O1 instance for parity.
module tb_receptor_words;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        rx_p;
    logic [15:0] data;
    logic        valid, frame_err, parity_err, timeout, busy;
    logic [15:0] data_p;
    logic        valid_p, frame_err_p, parity_err_p, timeout_p, busy_p;

    int n_total = 0;
    int n_bad   = 0;

    int cyc = 0;
    int n_valid, n_fe, n_pe, n_to, n_busy_rise;
    int np_valid, np_fe, np_pe;
    int busy_rise_cyc = 0, idle_cyc = 0, to_cyc = 0, lat = 0;
    logic busy_q = 1'b0;

    always #5 clk = ~clk;

    receptor_words #(.DATA_BITS(8), .BYTES(2), .OVERSAMPLE(16), .PARITY(0), .TIMEOUT_BITS(32)) dut (
        .clk_153k6hz(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
        .frame_err(frame_err), .parity_err(parity_err), .timeout(timeout), .busy(busy));

    receptor_words #(.DATA_BITS(8), .BYTES(2), .OVERSAMPLE(16), .PARITY(2), .TIMEOUT_BITS(32)) dut_p (
        .clk_153k6hz(clk), .rst_n(rst_n), .rx(rx_p), .data(data_p), .valid(valid_p),
        .frame_err(frame_err_p), .parity_err(parity_err_p), .timeout(timeout_p), .busy(busy_p));

    always @(posedge clk) begin
        #1;
        cyc++;
        if (valid) begin
            n_valid++;
            lat = cyc - busy_rise_cyc;
        end
        if (frame_err) n_fe++;
        if (parity_err) n_pe++;
        if (timeout) begin
            n_to++;
            to_cyc = cyc;
        end
        if (busy && !busy_q) begin
            n_busy_rise++;
            busy_rise_cyc = cyc;
        end
        if (!busy && busy_q) idle_cyc = cyc;
        busy_q = busy;
        if (valid_p) np_valid++;
        if (frame_err_p) np_fe++;
        if (parity_err_p) np_pe++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_valid = 0; n_fe = 0; n_pe = 0; n_to = 0; n_busy_rise = 0;
        np_valid = 0; np_fe = 0; np_pe = 0;
    endtask

    task automatic drive(input int line, input logic v, input int cycles);
        if (line == 0) rx = v;
        else rx_p = v;
        repeat (cycles) @(negedge clk);
    endtask

    // par < 0 sends no parity bit; otherwise par[0] is the parity bit sent.
    task automatic send_char(input int line, input logic [7:0] b, input int par, input logic stop);
        drive(line, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(line, b[i], 16);
        if (par >= 0) drive(line, par[0], 16);
        drive(line, stop, 16);
    endtask

    initial begin
        rx = 1'b1;
        rx_p = 1'b1;
        rst_n = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_flags", 32'({frame_err, parity_err, timeout}), 32'h0);
        check("rst_data_p", 32'(data_p), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // good word, 8N1
        clear_counts();
        send_char(0, 8'h34, -1, 1'b1);
        check("good_mid_valid", n_valid, 0);
        send_char(0, 8'h12, -1, 1'b1);
        drive(0, 1'b1, 16);
        check("good_valid_cnt", n_valid, 1);
        check("good_data", 32'(data), 32'h1234);
        check("good_latency", lat, 152);
        check("good_errs", n_fe + n_pe + n_to, 0);

        // false start
        clear_counts();
        drive(0, 1'b0, 6);
        drive(0, 1'b1, 30);
        check("fs_busy_rise", n_busy_rise, 1);
        check("fs_busy_low", 32'(busy), 32'h0);
        check("fs_no_flags", n_fe + n_pe + n_to + n_valid, 0);
        send_char(0, 8'hA5, -1, 1'b1);
        send_char(0, 8'h5A, -1, 1'b1);
        drive(0, 1'b1, 16);
        check("fs_data", 32'(data), 32'h5AA5);
        check("fs_valid_cnt", n_valid, 1);

        // framing error with a 3-bit-period break
        clear_counts();
        send_char(0, 8'h34, -1, 1'b1);
        send_char(0, 8'h12, -1, 1'b0);
        drive(0, 1'b0, 32);
        check("fe_cnt", n_fe, 1);
        check("fe_busy_break", 32'(busy), 32'h1);
        check("fe_data_hold", 32'(data), 32'h5AA5);
        check("fe_no_valid", n_valid, 0);
        drive(0, 1'b1, 8);
        check("fe_busy_release", 32'(busy), 32'h0);
        drive(0, 1'b1, 8);
        send_char(0, 8'h78, -1, 1'b1);
        send_char(0, 8'h56, -1, 1'b1);
        drive(0, 1'b1, 16);
        check("fe_data_after", 32'(data), 32'h5678);
        check("fe_valid_cnt", n_valid, 1);
        check("fe_cnt_final", n_fe, 1);
        check("fe_no_pe", n_pe, 0);

        // odd parity instance
        clear_counts();
        send_char(1, 8'h01, 1, 1'b1);
        drive(1, 1'b1, 16);
        check("par_err_cnt", np_pe, 1);
        check("par_no_valid", np_valid, 0);
        check("par_no_fe", np_fe, 0);
        send_char(1, 8'h01, 0, 1'b1);
        send_char(1, 8'h02, 0, 1'b1);
        drive(1, 1'b1, 16);
        check("par_data", 32'(data_p), 32'h0201);
        check("par_valid_cnt", np_valid, 1);
        check("par_err_final", np_pe, 1);

        // inter-byte timeout
        clear_counts();
        send_char(0, 8'h34, -1, 1'b1);
        drive(0, 1'b1, 600);
        check("to_cnt", n_to, 1);
        check("to_delay", to_cyc - idle_cyc, 512);
        check("to_no_valid", n_valid, 0);
        send_char(0, 8'hCD, -1, 1'b1);
        send_char(0, 8'hAB, -1, 1'b1);
        drive(0, 1'b1, 16);
        check("to_data", 32'(data), 32'hABCD);
        check("to_valid_cnt", n_valid, 1);
        check("to_cnt_final", n_to, 1);

        // reset during data bit 3 of 0x11
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 16);
        drive(0, 1'b0, 16);
        drive(0, 1'b0, 16);
        drive(0, 1'b0, 8);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_data", 32'(data), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_flags", 32'({valid, frame_err, parity_err, timeout}), 32'h0);
        check("mrst_data_p", 32'(data_p), 32'h0);
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        clear_counts();
        send_char(0, 8'h11, -1, 1'b1);
        send_char(0, 8'h22, -1, 1'b1);
        drive(0, 1'b1, 16);
        check("mrst_data_after", 32'(data), 32'h2211);
        check("mrst_valid_cnt", n_valid, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
